// File: rtl/sensor_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : sensor_frame_rx
// Purpose : Groups UART bytes into data/check frames, validates them with an
//           XOR key and presents one classified frame on a valid/ack handshake.
// Revision: 1.0  initial release
// ============================================================================
module sensor_frame_rx #(
    parameter logic [7:0] CHECK_KEY    = 8'h37,
    parameter logic [7:0] ALARM_CODE   = 8'h00,
    parameter int         BYTE_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_rdy_clr,
    input  logic       flush,
    output logic       frame_valid,
    output logic [7:0] frame_data,
    output logic [1:0] frame_status,
    input  logic       frame_ack,
    output logic [7:0] err_count
);

    localparam int             CW          = (BYTE_TIMEOUT > 255) ? $clog2(BYTE_TIMEOUT + 1) : 8;
    localparam logic [CW-1:0]  TIMEOUT_VAL = CW'(BYTE_TIMEOUT);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ALARM   = 2'b01;
    localparam logic [1:0] ST_CSUM    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        WAIT_FIRST  = 3'd0,
        DRAIN1      = 3'd1,
        WAIT_SECOND = 3'd2,
        DRAIN2      = 3'd3,
        CHECK       = 3'd4,
        HOLD        = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    first_q, first_d;
    logic [7:0]    second_q, second_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    status_q, status_d;
    logic [7:0]    err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clr_q, clr_d;
    logic          valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        second_d = second_q;
        data_d   = data_q;
        status_d = status_q;
        err_d    = err_q;
        cnt_d    = '0;

        case (state_q)
            WAIT_FIRST: begin
                if (rx_rdy) begin
                    first_d = rx_data;
                    state_d = DRAIN1;
                end
            end
            DRAIN1: begin
                if (!rx_rdy) state_d = WAIT_SECOND;
            end
            WAIT_SECOND: begin
                cnt_d = cnt_q + 1'b1;
                // A byte arriving in the timeout cycle takes precedence.
                if (rx_rdy) begin
                    second_d = rx_data;
                    state_d  = DRAIN2;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    data_d   = first_q;
                    status_d = ST_TIMEOUT;
                    state_d  = HOLD;
                end
            end
            DRAIN2: begin
                if (!rx_rdy) state_d = CHECK;
            end
            CHECK: begin
                data_d = first_q;
                if ((first_q ^ CHECK_KEY) == second_q)
                    status_d = (first_q == ALARM_CODE) ? ST_ALARM : ST_OK;
                else
                    status_d = ST_CSUM;
                state_d = HOLD;
            end
            HOLD: begin
                if (frame_ack) state_d = WAIT_FIRST;
            end
            default: state_d = WAIT_FIRST;
        endcase

        if (flush) begin
            state_d  = WAIT_FIRST;
            data_d   = data_q;
            status_d = status_q;
            cnt_d    = '0;
        end

        // Error frames are counted once, on the transition into HOLD.
        if (state_d == HOLD && state_q != HOLD && status_d[1] && err_q != 8'hFF)
            err_d = err_q + 8'd1;

        clr_d   = (state_d == DRAIN1) || (state_d == DRAIN2);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= WAIT_FIRST;
            first_q  <= 8'h00;
            second_q <= 8'h00;
            data_q   <= 8'h00;
            status_q <= ST_OK;
            err_q    <= 8'h00;
            cnt_q    <= '0;
            clr_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            second_q <= second_d;
            data_q   <= data_d;
            status_q <= status_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            clr_q    <= clr_d;
            valid_q  <= valid_d;
        end
    end

    assign rx_rdy_clr   = clr_q;
    assign frame_valid  = valid_q;
    assign frame_data   = data_q;
    assign frame_status = status_q;
    assign err_count    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_sensor_frame_rx
// Purpose : Self-checking bench for sensor_frame_rx with a UART byte model and
//           an expected-frame scoreboard.
// Revision: 1.0  initial release
// ============================================================================
module tb_sensor_frame_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_rdy_clr;
    logic       flush;
    logic       frame_valid;
    logic [7:0] frame_data;
    logic [1:0] frame_status;
    logic       frame_ack;
    logic [7:0] err_count;

    always #5 clock = ~clock;

    sensor_frame_rx dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .rx_rdy_clr   (rx_rdy_clr),
        .flush        (flush),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .frame_status (frame_status),
        .frame_ack    (frame_ack),
        .err_count    (err_count)
    );

    typedef struct {
        logic [7:0] dat;
        logic [1:0] st;
        logic [7:0] err;
    } exp_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] dat;
        logic [1:0] st;
    } vec_t;

    int         tests   = 0;
    int         fails   = 0;
    int         err_exp = 0;
    bit         stall   = 1'b0;
    exp_t       sb[$];
    logic [7:0] byteq[$];
    vec_t       vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] dat, input logic [1:0] st);
        exp_t e;
        if (st[1] && err_exp < 255) err_exp++;
        e.dat = dat;
        e.st  = st;
        e.err = 8'(err_exp);
        sb.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] dat, input logic [1:0] st);
        push_exp(dat, st);
        byteq.push_back(b0);
        byteq.push_back(b1);
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (sb.size() == 0 && byteq.size() == 0 && !rx_rdy) break;
            @(posedge clock); #1;
        end
        repeat (2) begin @(posedge clock); #1; end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_clr();
        for (int c = 0; c < 50; c++) begin
            @(posedge clock); #1;
            if (rx_rdy_clr) break;
        end
        chk("rx_rdy_clr_rise", 32'(rx_rdy_clr), 32'd1);
    endtask

    // UART model: holds a byte until rx_rdy_clr is seen, then offers the next.
    initial begin
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(negedge clock);
            if (reset)
                rx_rdy = 1'b0;
            else if (rx_rdy && rx_rdy_clr && !stall)
                rx_rdy = 1'b0;
            else if (!rx_rdy && byteq.size() > 0) begin
                rx_data = byteq.pop_front();
                rx_rdy  = 1'b1;
            end
        end
    end

    // Frame monitor: every accepted frame is checked against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (frame_valid && frame_ack && !reset) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got data 0x%0h status %0b, none expected",
                             frame_data, frame_status);
                end else begin
                    e = sb.pop_front();
                    chk("frame_data", 32'(frame_data), 32'(e.dat));
                    chk("frame_status", 32'(frame_status), 32'(e.st));
                    chk("err_count", 32'(err_count), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h25, 8'h12, 8'h25, 2'b00};
        vecs[1] = '{8'h00, 8'h37, 8'h00, 2'b01};
        vecs[2] = '{8'h25, 8'h13, 8'h25, 2'b10};
        vecs[3] = '{8'hA5, 8'h92, 8'hA5, 2'b00};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 2'b10};
        vecs[5] = '{8'hFF, 8'hC8, 8'hFF, 2'b00};
        vecs[6] = '{8'h37, 8'h00, 8'h37, 2'b00};

        reset     = 1'b1;
        flush     = 1'b0;
        frame_ack = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_clr", 32'(rx_rdy_clr), 32'd0);
        chk("rst_data", 32'(frame_data), 32'd0);
        chk("rst_status", 32'(frame_status), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 7; i++)
            push_frame(vecs[i].b0, vecs[i].b1, vecs[i].dat, vecs[i].st);
        wait_idle(500);

        // Lone first byte: timeout fires exactly when the counter hits 255.
        push_exp(8'h40, 2'b11);
        byteq.push_back(8'h40);
        wait_clr();
        repeat (256) @(posedge clock);
        #1;
        chk("timeout_not_early", 32'(frame_valid), 32'd0);
        @(posedge clock); #1;
        chk("timeout_valid", 32'(frame_valid), 32'd1);
        wait_idle(50);

        // Second byte lands in the timeout cycle: normal frame wins.
        push_exp(8'h40, 2'b00);
        byteq.push_back(8'h40);
        wait_clr();
        repeat (256) @(posedge clock);
        #1;
        byteq.push_back(8'h77);
        wait_idle(50);

        // Backpressure with a pending byte behind the held frame.
        frame_ack = 1'b0;
        push_frame(8'h25, 8'h12, 8'h25, 2'b00);
        push_exp(8'h30, 2'b00);
        byteq.push_back(8'h30);
        for (int c = 0; c < 50; c++) begin
            @(posedge clock); #1;
            if (frame_valid) break;
        end
        chk("bp_valid_rise", 32'(frame_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            chk("bp_valid", 32'(frame_valid), 32'd1);
            chk("bp_data", 32'(frame_data), 32'h25);
            chk("bp_status", 32'(frame_status), 32'd0);
            chk("bp_clr", 32'(rx_rdy_clr), 32'd0);
        end
        frame_ack = 1'b1;
        @(posedge clock); #1;
        chk("ack_drop_valid", 32'(frame_valid), 32'd0);
        chk("ack_idle_clr", 32'(rx_rdy_clr), 32'd0);
        @(posedge clock); #1;
        chk("pending_consumed", 32'(rx_rdy_clr), 32'd1);
        byteq.push_back(8'h07);
        wait_idle(100);

        // Flush drops a partial frame.
        byteq.push_back(8'h25);
        wait_clr();
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_valid", 32'(frame_valid), 32'd0);
        chk("flush_clr", 32'(rx_rdy_clr), 32'd0);
        push_frame(8'h12, 8'h25, 8'h12, 2'b00);
        wait_idle(100);

        // Error counter saturation.
        for (int i = 0; i < 300; i++)
            push_frame(8'h25, 8'h13, 8'h25, 2'b10);
        wait_idle(8000);
        chk("err_saturated", 32'(err_count), 32'd255);

        // Reset while parked in DRAIN2.
        byteq.push_back(8'h25);
        wait_clr();
        @(posedge clock); #1;
        stall = 1'b1;
        byteq.push_back(8'h12);
        wait_clr();
        @(posedge clock); #1;
        chk("drain2_hold_clr", 32'(rx_rdy_clr), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_valid", 32'(frame_valid), 32'd0);
        chk("midrst_clr", 32'(rx_rdy_clr), 32'd0);
        chk("midrst_data", 32'(frame_data), 32'd0);
        chk("midrst_status", 32'(frame_status), 32'd0);
        chk("midrst_err", 32'(err_count), 32'd0);
        reset   = 1'b0;
        stall   = 1'b0;
        err_exp = 0;
        @(posedge clock); #1;
        push_frame(8'h25, 8'h13, 8'h25, 2'b10);
        push_frame(8'h00, 8'h37, 8'h00, 2'b01);
        wait_idle(200);
        chk("bytes_consumed", 32'(byteq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
